// File: rtl/uart_mem_loader_if.sv
// Bundle of the UART byte streams, instruction-RAM write port and boot handoff
// seen by uart_mem_loader. The master modport is the loader side.
interface uart_mem_loader_if #(
  parameter int ADDR_W = 9
);
  // Handshake rule for both byte streams: a byte moves on a rising clk edge
  // where valid & ready are both 1; the sender holds data and valid until then.
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic              boot_go;
  logic [31:0]       boot_addr;
  logic              busy;
  logic [2:0]        dbg_state;

  modport master (
    input  rx_data, rx_valid, tx_ready,
    output rx_ready, tx_data, tx_valid, mem_addr, mem_din, mem_we,
           boot_go, boot_addr, busy, dbg_state
  );

  modport slave (
    output rx_data, rx_valid, tx_ready,
    input  rx_ready, tx_data, tx_valid, mem_addr, mem_din, mem_we,
           boot_go, boot_addr, busy, dbg_state
  );
endinterface

// File: rtl/uart_mem_loader.sv
// PLP boot loader: parses host bytes, writes big-endian words into instruction RAM,
// acks commands and issues the jump. Optional macro UART_MEM_LOADER_RANGE_CHECK_EN.
module uart_mem_loader #(
  parameter int          ADDR_W       = 9,
  parameter logic [7:0]  ACK_BYTE     = 8'h66,
  parameter logic [31:0] VERSION_WORD = 32'h706c7032
) (
  input  logic               clk,
  input  logic               rst_n,
  uart_mem_loader_if.master  io_bus
);

  localparam logic [7:0] NACK_BYTE = 8'h6e;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_COLLECT = 3'd1,
    S_WRITE   = 3'd2,
    S_ACK     = 3'd3,
    S_JUMP    = 3'd4,
    S_VER     = 3'd5
  } state_t;

  state_t            r_state,     w_state;
  logic              r_tgt_data,  w_tgt_data;
  logic              r_jump,      w_jump;
  logic [1:0]        r_cnt,       w_cnt;
  logic [23:0]       r_shift,     w_shift;
  logic [31:0]       r_addr,      w_addr;
  logic [7:0]        r_tx_data,   w_tx_data;
  logic              r_tx_valid,  w_tx_valid;
  logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr;
  logic [31:0]       r_mem_din,   w_mem_din;
  logic              r_mem_we,    w_mem_we;
  logic              r_boot_go,   w_boot_go;
  logic [31:0]       r_boot_addr, w_boot_addr;

  logic        w_rx_ready;
  logic        w_rx_fire;
  logic        w_tx_fire;
  logic [31:0] w_word;
  logic        w_oor;

  assign w_rx_ready = (r_state == S_IDLE) || (r_state == S_COLLECT);
  assign w_rx_fire  = io_bus.rx_valid & w_rx_ready;
  assign w_tx_fire  = r_tx_valid & io_bus.tx_ready;
  // Only the first three bytes are stored; the fourth completes the word as it arrives.
  assign w_word     = {r_shift, io_bus.rx_data};

`ifdef UART_MEM_LOADER_RANGE_CHECK_EN
  assign w_oor = |r_addr[31:ADDR_W+2];
`else
  assign w_oor = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_tgt_data  <= 1'b0;
      r_jump      <= 1'b0;
      r_cnt       <= 2'd0;
      r_shift     <= 24'd0;
      r_addr      <= 32'd0;
      r_tx_data   <= 8'd0;
      r_tx_valid  <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_din   <= 32'd0;
      r_mem_we    <= 1'b0;
      r_boot_go   <= 1'b0;
      r_boot_addr <= 32'd0;
    end else begin
      r_state     <= w_state;
      r_tgt_data  <= w_tgt_data;
      r_jump      <= w_jump;
      r_cnt       <= w_cnt;
      r_shift     <= w_shift;
      r_addr      <= w_addr;
      r_tx_data   <= w_tx_data;
      r_tx_valid  <= w_tx_valid;
      r_mem_addr  <= w_mem_addr;
      r_mem_din   <= w_mem_din;
      r_mem_we    <= w_mem_we;
      r_boot_go   <= w_boot_go;
      r_boot_addr <= w_boot_addr;
    end
  end

  // Outputs are registered, so each is computed on the transition into the state that owns it.
  always_comb begin
    w_state     = r_state;
    w_tgt_data  = r_tgt_data;
    w_jump      = r_jump;
    w_cnt       = r_cnt;
    w_shift     = r_shift;
    w_addr      = r_addr;
    w_tx_data   = r_tx_data;
    w_tx_valid  = r_tx_valid;
    w_mem_addr  = r_mem_addr;
    w_mem_din   = r_mem_din;
    w_mem_we    = 1'b0;
    w_boot_go   = 1'b0;
    w_boot_addr = r_boot_addr;

    case (r_state)
      S_IDLE: begin
        if (w_rx_fire) begin
          case (io_bus.rx_data)
            8'h61: begin
              w_state    = S_COLLECT;
              w_tgt_data = 1'b0;
              w_cnt      = 2'd0;
            end
            8'h64: begin
              w_state    = S_COLLECT;
              w_tgt_data = 1'b1;
              w_cnt      = 2'd0;
            end
            8'h6a: begin
              w_state    = S_ACK;
              w_jump     = 1'b1;
              w_tx_valid = 1'b1;
              w_tx_data  = ACK_BYTE;
            end
            8'h76: begin
              w_state    = S_VER;
              w_cnt      = 2'd0;
              w_tx_valid = 1'b1;
              w_tx_data  = VERSION_WORD[31:24];
            end
            default: w_state = S_IDLE;
          endcase
        end
      end

      S_COLLECT: begin
        if (w_rx_fire) begin
          w_shift = w_word[23:0];
          if (r_cnt == 2'd3) begin
            w_cnt = 2'd0;
            if (r_tgt_data) begin
              w_state    = S_WRITE;
              w_mem_we   = !w_oor;
              w_mem_addr = r_addr[ADDR_W+1:2];
              w_mem_din  = w_word;
            end else begin
              w_state    = S_ACK;
              w_addr     = w_word;
              w_tx_valid = 1'b1;
              w_tx_data  = ACK_BYTE;
            end
          end else begin
            w_cnt = r_cnt + 2'd1;
          end
        end
      end

      S_WRITE: begin
        // The suppressed-write verdict is taken from the pre-increment address.
        w_addr     = r_addr + 32'd4;
        w_state    = S_ACK;
        w_tx_valid = 1'b1;
        w_tx_data  = w_oor ? NACK_BYTE : ACK_BYTE;
      end

      S_ACK: begin
        if (w_tx_fire) begin
          w_tx_valid = 1'b0;
          if (r_jump) begin
            w_state     = S_JUMP;
            w_boot_go   = 1'b1;
            w_boot_addr = r_addr;
          end else begin
            w_state = S_IDLE;
          end
        end
      end

      S_JUMP: begin
        w_jump  = 1'b0;
        w_state = S_IDLE;
      end

      S_VER: begin
        if (w_tx_fire) begin
          if (r_cnt == 2'd3) begin
            w_tx_valid = 1'b0;
            w_cnt      = 2'd0;
            w_state    = S_IDLE;
          end else begin
            w_cnt = r_cnt + 2'd1;
            case (r_cnt)
              2'd0:    w_tx_data = VERSION_WORD[23:16];
              2'd1:    w_tx_data = VERSION_WORD[15:8];
              default: w_tx_data = VERSION_WORD[7:0];
            endcase
          end
        end
      end

      default: w_state = S_IDLE;
    endcase
  end

  assign io_bus.rx_ready  = w_rx_ready;
  assign io_bus.tx_data   = r_tx_data;
  assign io_bus.tx_valid  = r_tx_valid;
  assign io_bus.mem_addr  = r_mem_addr;
  assign io_bus.mem_din   = r_mem_din;
  assign io_bus.mem_we    = r_mem_we;
  assign io_bus.boot_go   = r_boot_go;
  assign io_bus.boot_addr = r_boot_addr;
  assign io_bus.busy      = (r_state != S_IDLE);
  assign io_bus.dbg_state = r_state;

endmodule
